ps2_mouse_kempston: RTL and testbench

- Consumes the byte stream produced by the PS/2 receiver when it runs in mouse mode (1-clk strobe plus an 8-bit byte, no E0/F0 handling).
- Assembles standard 3-byte PS/2 mouse packets and accumulates movement into Kempston-mouse-compatible X/Y position registers and a button register.
- The ULA/port decoder reads these registers directly.
- Resynchronises on framing errors and on inter-byte timeouts.

---
 rtl/ps2_mouse_kempston.sv | 100 ++++++++++
 tb/tb_ps2_mouse_kempston.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_kempston.sv
// Assembles 3-byte PS/2 mouse packets and accumulates them into Kempston X/Y and button registers.
// Resynchronises on a bad status byte or an inter-byte timeout.
module ps2_mouse_kempston #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter bit SWAP_BUTTONS   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rcv_strobe,
  input  logic [7:0] rcv_data,
  output logic [7:0] kmouse_x,
  output logic [7:0] kmouse_y,
  output logic [7:0] kmouse_buttons,
  output logic       packet_valid,
  output logic       sync_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] tcnt;
  logic [7:0]    dx;
  logic          ovf_x, ovf_y, btn_m, btn_l, btn_r;
  logic          timeout;

  assign timeout = (tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_B0;
      tcnt           <= '0;
      dx             <= '0;
      ovf_x          <= 1'b0;
      ovf_y          <= 1'b0;
      btn_m          <= 1'b0;
      btn_l          <= 1'b0;
      btn_r          <= 1'b0;
      kmouse_x       <= 8'h00;
      kmouse_y       <= 8'h00;
      kmouse_buttons <= 8'hFF;
      packet_valid   <= 1'b0;
      sync_error     <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
      if (!enable) begin
        // Drop any partial packet quietly; outputs hold.
        state <= WAIT_B0;
        tcnt  <= '0;
      end else begin
        case (state)
          WAIT_B0: begin
            tcnt <= '0;
            if (rcv_strobe) begin
              if (rcv_data[3]) begin
                ovf_y <= rcv_data[7];
                ovf_x <= rcv_data[6];
                btn_m <= rcv_data[2];
                btn_l <= SWAP_BUTTONS ? rcv_data[1] : rcv_data[0];
                btn_r <= SWAP_BUTTONS ? rcv_data[0] : rcv_data[1];
                state <= WAIT_B1;
              end else begin
                sync_error <= 1'b1;
              end
            end
          end
          WAIT_B1, WAIT_B2: begin
            // An arriving byte wins over a timeout firing in the same cycle.
            if (rcv_strobe) begin
              tcnt <= '0;
              if (state == WAIT_B1) begin
                dx    <= rcv_data;
                state <= WAIT_B2;
              end else begin
                if (!ovf_x) kmouse_x <= kmouse_x + dx;
                if (!ovf_y) kmouse_y <= kmouse_y + rcv_data;
                kmouse_buttons <= {5'b11111, ~btn_m, ~btn_l, ~btn_r};
                packet_valid   <= 1'b1;
                state          <= WAIT_B0;
              end
            end else if (timeout) begin
              tcnt       <= '0;
              sync_error <= 1'b1;
              state      <= WAIT_B0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          default: begin
            state <= WAIT_B0;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_mouse_kempston.sv
// Randomised scoreboard bench for ps2_mouse_kempston: a packet-level model queues expected
// pulses and a negedge monitor compares them against the DUT.
module tb_ps2_mouse_kempston;
  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       rcv_strobe = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic [7:0] kmouse_x, kmouse_y, kmouse_buttons;
  logic       packet_valid, sync_error;

  ps2_mouse_kempston #(.TIMEOUT_CYCLES(T), .SWAP_BUTTONS(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rcv_strobe(rcv_strobe), .rcv_data(rcv_data),
    .kmouse_x(kmouse_x), .kmouse_y(kmouse_y), .kmouse_buttons(kmouse_buttons),
    .packet_valid(packet_valid), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         pkt;
    logic [7:0] x, y, b;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  // Reference model: packet-level view of the stream.
  int         phase = 0;
  logic [7:0] mb0, mdx;
  logic [7:0] mx = 8'h00, my = 8'h00, mbtn = 8'hFF;

  task automatic push_sync();
    ev_t e;
    e.pkt = 1'b0; e.x = 8'h00; e.y = 8'h00; e.b = 8'h00;
    q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] d);
    ev_t e;
    if (phase == 0) begin
      if (d[3]) begin mb0 = d; phase = 1; end
      else push_sync();
    end else if (phase == 1) begin
      mdx = d; phase = 2;
    end else begin
      if (!mb0[6]) mx = mx + mdx;
      if (!mb0[7]) my = my + d;
      mbtn = {5'b11111, ~mb0[2], ~mb0[0], ~mb0[1]};
      e.pkt = 1'b1; e.x = mx; e.y = my; e.b = mbtn;
      q.push_back(e);
      phase = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A partial packet is lost once T or more idle cycles follow its last byte.
  task automatic idle(input int n);
    if (phase != 0 && n >= T) begin push_sync(); phase = 0; end
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    idle(gap);
    rcv_strobe = 1'b1;
    rcv_data   = d;
    model_byte(d);
    tick();
    rcv_strobe = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 0); send(b, 1); send(c, 2);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mx = 8'h00; my = 8'h00; mbtn = 8'hFF; phase = 0;
    check8("rst_x", kmouse_x, 8'h00);
    check8("rst_y", kmouse_y, 8'h00);
    check8("rst_btn", kmouse_buttons, 8'hFF);
    check8("rst_pulses", {6'd0, packet_valid, sync_error}, 8'h00);
    check8("rst_queue_empty", 8'(q.size()), 8'h00);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (packet_valid && sync_error) begin
        checks++; errors++;
        $display("FAIL both_pulses pv=%0b se=%0b want exclusive", packet_valid, sync_error);
      end else if (packet_valid || sync_error) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse pv=%0b se=%0b want none", packet_valid, sync_error);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.pkt != packet_valid ||
              (mon_e.pkt && (kmouse_x !== mon_e.x || kmouse_y !== mon_e.y ||
                             kmouse_buttons !== mon_e.b))) begin
            errors++;
            $display("FAIL event pv=%0b x=%h y=%h b=%h want pv=%0b x=%h y=%h b=%h",
                     packet_valid, kmouse_x, kmouse_y, kmouse_buttons,
                     mon_e.pkt, mon_e.x, mon_e.y, mon_e.b);
          end
        end
      end
    end
  end

  initial begin
    int r, gap;
    logic [7:0] d;
    tick();
    do_reset();

    // Directed cases
    send3(8'h08, 8'h05, 8'h03);
    send3(8'h08, 8'hFD, 8'hFE);          // back to x=02, y=01
    send3(8'h3B, 8'hFC, 8'hFE);          // negative X/Y, left+right
    send3(8'h08, 8'hF2, 8'h00);          // x=F0
    send3(8'h48, 8'h20, 8'h10);          // X overflow
    send(8'h00, 1);                      // bad status byte
    send3(8'h08, 8'h01, 8'h01);
    send(8'h08, 0); send(8'h05, 0);
    idle(T);                             // timeout
    send3(8'h09, 8'h01, 8'h00);
    send(8'h08, 0); send(8'h02, T - 1); send(8'h03, T - 1);  // strobe on the timeout cycle
    send(8'h08, 0); send(8'h05, 0);
    do_reset();                          // reset mid-packet
    send(8'h05, 0);                      // treated as byte0 -> sync error
    send3(8'h08, 8'h02, 8'h04);
    send(8'h08, 0);
    enable = 1'b0; tick(); enable = 1'b1; phase = 0;
    send(8'h07, 1);                      // byte0 again after enable drop

    // Randomised stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        enable = 1'b1;
        phase = 0;
      end
      if (r == 1) gap = T + $urandom_range(0, 5);
      else if (r == 2) gap = T - 1;
      else gap = $urandom_range(0, 3);
      d = 8'($urandom());
      if (phase == 0 && $urandom_range(0, 3) != 0) d[3] = 1'b1;
      send(d, gap);
    end

    repeat (3) tick();
    check8("queue_drained", 8'(q.size()), 8'h00);
    check8("final_x", kmouse_x, mx);
    check8("final_y", kmouse_y, my);
    check8("final_btn", kmouse_buttons, mbtn);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
